hazard_ctl: RTL and testbench

HAZARD_CTL -- requirements
Module: hazard_ctl

---
 rtl/hazard_ctl_pkg.sv | 28 ++
 rtl/hazard_ctl_raw_detect.sv | 27 ++
 rtl/hazard_ctl.sv | 112 +++++++++++
 tb/tb_hazard_ctl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding,
// the NOP opcode loaded on a flush, and the bubble counter ceiling.
package hazard_ctl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        DISCARD = 2'b01,
        HALT    = 2'b10
    } state_t;

    localparam logic [4:0]  NOP_OPCODE = 5'b00001;
    localparam logic [15:0] BUBBLE_MAX = 16'hFFFF;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctl_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == BUBBLE_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_ctl_raw_detect.sv
// Read-after-write detection between the ID instruction and the EX/MEM
// instructions; WB is covered by the register-file bypass and is not checked.
module raw_detect
    import hazard_ctl_pkg::*;
(
    input  logic [2:0] id_rs,
    input  logic [2:0] id_rt,
    input  logic       id_rs_use,
    input  logic       id_rt_use,
    input  logic [2:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic [2:0] mem_rd,
    input  logic       mem_reg_write,
    output logic       hz
);

    logic ex_hit;
    logic mem_hit;

    // R0 is deliberately not special-cased: a write to R0 still stalls.
    assign ex_hit  = ex_reg_write & ((id_rs_use & (id_rs == ex_rd)) |
                                     (id_rt_use & (id_rt == ex_rd)));
    assign mem_hit = mem_reg_write & ((id_rs_use & (id_rs == mem_rd)) |
                                      (id_rt_use & (id_rt == mem_rd)));
    assign hz      = ex_hit | mem_hit;

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: stall/flush/freeze decisions, halt latch and
// a saturating count of bubbles injected into ID/EX.
module hazard_ctl
    import hazard_ctl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_rs_use,
    input  logic        id_rt_use,
    input  logic [2:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic [2:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic        ex_redirect,
    input  logic        imem_stall,
    input  logic        dmem_stall,
    input  logic        wb_halt,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [15:0] bubble_cnt
);

    state_t      state;
    state_t      state_next;
    ctl_t        ctl;
    logic        halted_c;
    logic        hz;
    logic [15:0] cnt;

    raw_detect u_raw_detect (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rs_use     (id_rs_use),
        .id_rt_use     (id_rt_use),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .hz            (hz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 16'd0;
        end else begin
            state <= state_next;
            if (ctl.idex_en && ctl.idex_flush) begin
                cnt <= sat_inc(cnt);
            end
        end
    end

    // Priority chain: reset, halt state, wb_halt, dmem freeze, redirect,
    // RAW hazard, discard completion, imem stall, normal flow.
    always_comb begin
        state_next = state;
        ctl        = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                       exmem_en: 1'b1, memwb_en: 1'b1,
                       ifid_flush: 1'b0, idex_flush: 1'b0};
        halted_c   = 1'b0;

        if (rst) begin
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
            state_next     = RUN;
        end else if (state == HALT) begin
            ctl      = '0;
            halted_c = 1'b1;
        end else if (wb_halt) begin
            ctl        = '0;
            state_next = HALT;
        end else if (dmem_stall) begin
            ctl = '0;
        end else if (ex_redirect) begin
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
            state_next     = imem_stall ? DISCARD : RUN;
        end else if (hz) begin
            ctl.pc_en      = 1'b0;
            ctl.ifid_en    = 1'b0;
            ctl.idex_flush = 1'b1;
        end else if (state == DISCARD || imem_stall) begin
            // The wrong-path fetch must land as a NOP, so discard completion
            // and an ordinary fetch stall drive identical controls.
            ctl.pc_en      = 1'b0;
            ctl.ifid_flush = 1'b1;
            state_next     = (state == DISCARD && imem_stall) ? DISCARD : RUN;
        end else begin
            state_next = RUN;
        end
    end

    assign pc_en      = ctl.pc_en;
    assign ifid_en    = ctl.ifid_en;
    assign idex_en    = ctl.idex_en;
    assign exmem_en   = ctl.exmem_en;
    assign memwb_en   = ctl.memwb_en;
    assign ifid_flush = ctl.ifid_flush;
    assign idex_flush = ctl.idex_flush;
    assign halted     = halted_c;
    assign bubble_cnt = cnt;

endmodule

// File: tb/tb_hazard_ctl.sv
// Randomized and directed bench for hazard_ctl, checked through a scoreboard
// fed by a behavioural model of the stall/flush priority rules.
module tb_hazard_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic        id_rs_use, id_rt_use, ex_reg_write, mem_reg_write;
    logic        ex_redirect, imem_stall, dmem_stall, wb_halt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, halted;
    logic [15:0] bubble_cnt;

    typedef struct {
        logic [6:0]  ctl;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    bit m_halted  = 1'b0;
    bit m_discard = 1'b0;
    int m_cnt     = 0;

    always #5 clk = ~clk;

    hazard_ctl dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rs_use     (id_rs_use),
        .id_rt_use     (id_rt_use),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .ex_redirect   (ex_redirect),
        .imem_stall    (imem_stall),
        .dmem_stall    (dmem_stall),
        .wb_halt       (wb_halt),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .halted        (halted),
        .bubble_cnt    (bubble_cnt)
    );

    // Drives one cycle of inputs and predicts the outputs from the rules.
    // Control vector order: pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush.
    task automatic applyStimulus(input logic r, input logic [2:0] rs, input logic [2:0] rt,
                                 input logic rs_u, input logic rt_u,
                                 input logic [2:0] erd, input logic ew,
                                 input logic [2:0] mrd, input logic mw,
                                 input logic redir, input logic imem,
                                 input logic dmem, input logic halt);
        exp_t e;
        bit   raw;
        bit   bubble;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt; id_rs_use = rs_u; id_rt_use = rt_u;
        ex_rd = erd; ex_reg_write = ew; mem_rd = mrd; mem_reg_write = mw;
        ex_redirect = redir; imem_stall = imem; dmem_stall = dmem; wb_halt = halt;

        raw = 1'b0;
        if (ew && ((rs_u && rs == erd) || (rt_u && rt == erd))) raw = 1'b1;
        if (mw && ((rs_u && rs == mrd) || (rt_u && rt == mrd))) raw = 1'b1;

        e.cnt    = 16'(m_cnt);
        e.halted = 1'b0;
        bubble   = 1'b0;
        if (r) begin
            e.ctl = 7'b11111_11;
            m_halted = 1'b0; m_discard = 1'b0; m_cnt = 0;
        end else if (m_halted) begin
            e.ctl = 7'b00000_00;
            e.halted = 1'b1;
        end else if (halt) begin
            e.ctl = 7'b00000_00;
            m_halted = 1'b1;
        end else if (dmem) begin
            e.ctl = 7'b00000_00;
        end else if (redir) begin
            e.ctl = 7'b11111_11;
            bubble = 1'b1;
            m_discard = imem;
        end else if (raw) begin
            e.ctl = 7'b00111_01;
            bubble = 1'b1;
        end else if (m_discard || imem) begin
            e.ctl = 7'b01111_10;
            m_discard = m_discard && imem;
        end else begin
            e.ctl = 7'b11111_00;
        end
        if (bubble && m_cnt < 65535) m_cnt = m_cnt + 1;
        exp_q.push_back(e);
    endtask

    task automatic idleCycle(input logic r);
        applyStimulus(r, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [6:0] got;
        got = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
        n_checks++;
        if (got !== e.ctl) begin
            n_fail++;
            $display("[TB] FAIL controls at %0t: got %b expected %b", $time, got, e.ctl);
        end
        n_checks++;
        if (halted !== e.halted) begin
            n_fail++;
            $display("[TB] FAIL halted at %0t: got %b expected %b", $time, halted, e.halted);
        end
        n_checks++;
        if (bubble_cnt !== e.cnt) begin
            n_fail++;
            $display("[TB] FAIL bubble_cnt at %0t: got %h expected %h", $time, bubble_cnt, e.cnt);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; id_rs = '0; id_rt = '0; id_rs_use = 1'b0; id_rt_use = 1'b0;
        ex_rd = '0; ex_reg_write = 1'b0; mem_rd = '0; mem_reg_write = 1'b0;
        ex_redirect = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0; wb_halt = 1'b0;

        idleCycle(1'b1);
        idleCycle(1'b0);

        // EX then MEM RAW hazard on r3: two bubbles.
        applyStimulus(1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 3'd3, 3'd0, 1'b1, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0);

        // Redirect under a fetch stall, discard for two more cycles, then complete.
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycle(1'b0);
        idleCycle(1'b0);

        // dmem freeze dominates a hazard and a redirect.
        repeat (3) applyStimulus(1'b0, 3'd5, 3'd0, 1'b1, 1'b0, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idleCycle(1'b0);

        // rt not used: matching rt must not stall.
        applyStimulus(1'b0, 3'd1, 3'd4, 1'b1, 1'b0, 3'd4, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Halt persists through hazards and stalls until reset.
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (5) applyStimulus(1'b0, 3'd2, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idleCycle(1'b1);
        idleCycle(1'b0);

        // Reset during a dmem freeze and during DISCARD.
        applyStimulus(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycle(1'b0);

        // Randomized traffic, with occasional resets to recover from halts.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 31) == 0),
                          3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                          1'($urandom), 1'($urandom),
                          3'($urandom_range(0, 7)), 1'($urandom),
                          3'($urandom_range(0, 7)), 1'($urandom),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0));
        end

        // Saturation of the bubble counter.
        idleCycle(1'b1);
        repeat (65540) applyStimulus(1'b0, 3'd6, 3'd0, 1'b1, 1'b0, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycle(1'b0);
        idleCycle(1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
